// File: rtl/conv_pkg.sv
// Shared definitions for the convolution scheduler: FSM states, default job
// sizes and the engine word-type tags.
package conv_pkg;

  localparam int IN_WORDS_DEF   = 289;
  localparam int W_WORDS_DEF    = 36;
  localparam int OUT_WORDS_DEF  = 256;
  localparam int FIFO_DEPTH_DEF = 4;

  localparam logic D_TYPE_INPUT  = 1'b0;
  localparam logic D_TYPE_WEIGHT = 1'b1;

  typedef enum logic [5:0] {
    IDLE  = 6'b000001,
    START = 6'b000010,
    LOAD  = 6'b000100,
    RUN   = 6'b001000,
    DRAIN = 6'b010000,
    DONE  = 6'b100000
  } state_t;

endpackage

// File: rtl/conv_sched_fifo.sv
// Small synchronous FIFO for engine results: count-based full/empty, flush,
// and a one-cycle overflow strobe when a push is dropped.
module conv_sched_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             empty,
  output logic             ovf
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             full;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  // A pop in the same cycle frees the slot, so a push into a full FIFO is kept.
  assign do_push = push && (!full || do_pop);
  assign ovf     = push && full && !do_pop;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      // NOTE: storage is reset only because it is tiny and the head drives a
      // port that must read 0 after reset; larger memories are left unreset.
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

endmodule

// File: rtl/conv_sched.sv
// Job sequencer for the 3x3 conv engine: merges input/weight streams into the
// engine load port with round-robin arbitration, then buffers results.
module conv_sched
  import conv_pkg::*;
#(
  parameter int IN_WORDS   = IN_WORDS_DEF,
  parameter int W_WORDS    = W_WORDS_DEF,
  parameter int OUT_WORDS  = OUT_WORDS_DEF,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_start,
  output logic        cmd_busy,
  output logic        cmd_done,
  output logic        err_ovf,
  input  logic [31:0] in_data,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] w_data,
  input  logic        w_valid,
  output logic        w_ready,
  output logic        eng_start,
  output logic [31:0] eng_i_data,
  output logic        eng_i_valid,
  output logic        eng_d_type,
  input  logic [31:0] eng_o_data,
  input  logic        eng_o_valid,
  input  logic        eng_finish,
  output logic [31:0] out_data,
  output logic        out_valid,
  input  logic        out_ready
);

  localparam logic [8:0] IN_LIM  = 9'(IN_WORDS);
  localparam logic [5:0] W_LIM   = 6'(W_WORDS);
  localparam logic [8:0] OUT_LIM = 9'(OUT_WORDS);

  state_t     state, state_d;
  logic [8:0] in_cnt, in_cnt_d;
  logic [5:0] w_cnt, w_cnt_d;
  logic [8:0] out_cnt;
  logic       fin_seen;
  logic       last_w;
  logic       start_acc;
  logic       in_elig, w_elig;
  logic       grant_in, grant_w;
  logic       push, pop;
  logic       fifo_empty, fifo_ovf;

  assign start_acc = (state == IDLE) && cmd_start;
  assign in_elig   = in_valid && (in_cnt < IN_LIM);
  assign w_elig    = w_valid && (w_cnt < W_LIM);

  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no
    // path leaves it unassigned, which would infer a latch.
    grant_in = 1'b0;
    grant_w  = 1'b0;
    if (state == LOAD) begin
      if (in_elig && w_elig) begin
        grant_in = last_w;
        grant_w  = !last_w;
      end else begin
        grant_in = in_elig;
        grant_w  = w_elig;
      end
    end
  end

  assign in_ready  = grant_in;
  assign w_ready   = grant_w;
  assign in_cnt_d  = in_cnt + 9'(grant_in);
  assign w_cnt_d   = w_cnt + 6'(grant_w);
  assign cmd_busy  = (state != IDLE);
  assign push      = eng_o_valid && (state inside {RUN, DRAIN});
  assign out_valid = !fifo_empty;
  assign pop       = out_valid && out_ready;

  always_comb begin
    state_d = state;
    unique case (state)
      IDLE:    if (cmd_start) state_d = START;
      START:   state_d = LOAD;
      // Leave as soon as the final word is taken, so LOAD costs no idle cycle.
      LOAD:    if (in_cnt_d == IN_LIM && w_cnt_d == W_LIM) state_d = RUN;
      RUN:     if (eng_o_valid && out_cnt == OUT_LIM - 9'd1) state_d = DRAIN;
      DRAIN:   if (fifo_empty && fin_seen) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      in_cnt      <= '0;
      w_cnt       <= '0;
      out_cnt     <= '0;
      fin_seen    <= 1'b0;
      err_ovf     <= 1'b0;
      last_w      <= 1'b1;
      eng_start   <= 1'b0;
      eng_i_data  <= '0;
      eng_i_valid <= 1'b0;
      eng_d_type  <= 1'b0;
      cmd_done    <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values regardless of statement order.
      state       <= state_d;
      eng_start   <= (state_d == START);
      cmd_done    <= (state_d == DONE);
      eng_i_valid <= grant_in || grant_w;
      if (grant_in || grant_w) begin
        eng_i_data <= grant_w ? w_data : in_data;
        eng_d_type <= grant_w ? D_TYPE_WEIGHT : D_TYPE_INPUT;
        last_w     <= grant_w;
      end
      if (start_acc) begin
        in_cnt   <= '0;
        w_cnt    <= '0;
        out_cnt  <= '0;
        fin_seen <= 1'b0;
        err_ovf  <= 1'b0;
        last_w   <= 1'b1;
      end else begin
        in_cnt <= in_cnt_d;
        w_cnt  <= w_cnt_d;
        if (state == RUN && eng_o_valid) out_cnt <= out_cnt + 9'd1;
        if (eng_finish && (state inside {LOAD, RUN, DRAIN})) fin_seen <= 1'b1;
        if (fifo_ovf) err_ovf <= 1'b1;
      end
    end
  end

  conv_sched_fifo #(
    .DEPTH(FIFO_DEPTH),
    .WIDTH(32)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (start_acc),
    .push     (push),
    .push_data(eng_o_data),
    .pop      (pop),
    .head     (out_data),
    .empty    (fifo_empty),
    .ovf      (fifo_ovf)
  );

endmodule
